// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed seven-segment display with a double-buffered digit snapshot.
// Optional `LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        digit_idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] shadow, active, active_nxt;
    logic                    pending, boundary, transfer, frame_nxt;
    logic [3:0]              code, bcd_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    lead;
`endif

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = digit_idx;
        boundary  = 1'b0;
        frame_nxt = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
                BLANK: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST) state_nxt = SHOW;
                end
                SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = BLANK;
                        if (digit_idx == IDX_LAST) begin
                            idx_nxt   = '0;
                            boundary  = 1'b1;
                            frame_nxt = 1'b1;
                        end else begin
                            idx_nxt = digit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end

        transfer   = pending && (boundary || state == IDLE);
        active_nxt = transfer ? shadow : active;

        code = 4'hF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) code = active_nxt[4*i +: 4];
        end
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (active_nxt[4*i +: 4] != 4'd0) lead = 1'b0;
            if (lead && idx_nxt == IDX_W'(i)) code = 4'hF;
        end
`endif
        bcd_nxt = (state_nxt == IDLE) ? 4'hF : code;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_nxt[i] = !(state_nxt == SHOW && idx_nxt == IDX_W'(i));
        end
    end

    // A load coinciding with a transfer wins the pending flag, so the new value waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            digit_idx  <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            bcd_out    <= 4'hF;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            digit_idx  <= idx_nxt;
            active     <= active_nxt;
            if (load) begin
                shadow  <= digits_in;
                pending <= 1'b1;
            end else if (transfer) begin
                pending <= 1'b0;
            end
            bcd_out    <= bcd_nxt;
            an         <= an_nxt;
            frame_done <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-position model checked every cycle, plus literal spot checks.
// Honours `LEADING_ZERO_BLANK_EN the same way as the design.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   digits_in = 16'h0;
    logic [3:0]    bcd_out;
    logic [ND-1:0] an;
    logic          frame_done;

    int vectors = 0;
    int miscompares = 0;

    bit          run = 1'b0;
    int          t = 0;
    logic [15:0] m_shadow = 16'h0, m_active = 16'h0;
    bit          m_pending = 1'b0;
    bit          was_idle, boundary, transfer;
    logic [3:0]  exp_an = 4'hF, exp_bcd = 4'hF;
    logic        exp_fd = 1'b0;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .digits_in(digits_in), .bcd_out(bcd_out), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_code(logic [15:0] a, int slot);
        logic [15:0] upper;
        upper = a >> (4 * slot);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && upper == 16'h0) return 4'hF;
`endif
        return upper[3:0];
    endfunction

    // Model tracks cycles since scanning started and derives slot/position from that count.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            run = 1'b0; t = 0;
            m_shadow = 16'h0; m_active = 16'h0; m_pending = 1'b0;
        end else begin
            was_idle = !run;
            boundary = run && enable && (t % FRAME == FRAME - 1);
            transfer = m_pending && (boundary || was_idle);
            if (transfer) m_active = m_shadow;
            if (load) begin
                m_shadow = digits_in; m_pending = 1'b1;
            end else if (transfer) begin
                m_pending = 1'b0;
            end
            if (!enable) begin
                run = 1'b0; t = 0;
            end else if (was_idle) begin
                run = 1'b1; t = 0;
            end else begin
                t++;
            end
        end
        if (!run) begin
            exp_an = 4'hF; exp_bcd = 4'hF; exp_fd = 1'b0;
        end else begin
            int phase, slot, pos;
            phase   = t % FRAME;
            slot    = phase / RD;
            pos     = phase % RD;
            exp_an  = (pos < BC) ? 4'hF : ~(4'b0001 << slot);
            exp_bcd = exp_code(m_active, slot);
            exp_fd  = (phase == 0 && t > 0);
        end
    end

    initial forever begin
        @(negedge clk);
        vectors++;
        if (an !== exp_an || bcd_out !== exp_bcd || frame_done !== exp_fd) begin
            miscompares++;
            $display("[TB] FAIL cycle_model @%0t: an=%b bcd=%h fd=%b, required an=%b bcd=%h fd=%b",
                     $time, an, bcd_out, frame_done, exp_an, exp_bcd, exp_fd);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [3:0] ea, input logic [3:0] eb);
        vectors++;
        if (an !== ea || bcd_out !== eb) begin
            miscompares++;
            $display("[TB] FAIL %s: an=%b bcd=%h, required an=%b bcd=%h", name, an, bcd_out, ea, eb);
        end
    endtask

    task automatic check_fd(input string name, input logic e);
        vectors++;
        if (frame_done !== e) begin
            miscompares++;
            $display("[TB] FAIL %s: frame_done=%b, required %b", name, frame_done, e);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic ld, input logic [15:0] d);
        enable = en; load = ld; digits_in = d;
    endtask

    initial begin
        step(3);
        check_output("reset_state", 4'hF, 4'hF);
        check_fd("reset_fd", 1'b0);
        rst_n = 1'b1;
        step(1);

        // Load while idle, then scan 1234
        apply_stimulus(0, 1, 16'h1234); step(1);
        apply_stimulus(0, 0, 16'h0);    step(1);
        enable = 1'b1; step(1);           // t=0
        check_output("t0_blank_d0", 4'hF, 4'h4);
        step(1); check_output("t1_blank_d0", 4'hF, 4'h4);
        step(1); check_output("t2_show_d0", 4'hE, 4'h4);
        step(6); check_output("t8_blank_d1", 4'hF, 4'h3);
        step(2); check_output("t10_show_d1", 4'hD, 4'h3);
        step(8); check_output("t18_show_d2", 4'hB, 4'h2);
        step(8); check_output("t26_show_d3", 4'h7, 4'h1);
        step(6); check_output("t32_frame2", 4'hF, 4'h4);
        check_fd("t32_frame_done", 1'b1);
        step(1); check_fd("t33_fd_clear", 1'b0);

        // Mid-frame load during digit 1
        step(9);                              // t=42
        load = 1'b1; digits_in = 16'h5678; step(1);
        load = 1'b0;
        step(15); check_output("t58_old_frame", 4'h7, 4'h1);
        step(6);  check_output("t64_new_d0", 4'hF, 4'h8);
        step(8);  check_output("t72_new_d1", 4'hF, 4'h7);

        // Load coincident with the frame boundary
        step(1); load = 1'b1; digits_in = 16'h4321; step(1);
        load = 1'b0;
        step(21); load = 1'b1; digits_in = 16'h8888; step(1);   // t=96
        load = 1'b0;
        check_output("t96_old_shadow", 4'hF, 4'h1);
        step(32); check_output("t128_new_shadow", 4'hF, 4'h8);

        // Enable dropped during SHOW of digit 2
        step(18); check_output("t146_show_d2", 4'hB, 4'h8);
        enable = 1'b0; step(1);
        check_output("disable_dark", 4'hF, 4'hF);
        step(3);
        enable = 1'b1; step(1); check_output("restart_d0_blank", 4'hF, 4'h8);
        step(2); check_output("restart_d0_show", 4'hE, 4'h8);

        // Leading-zero handling
        apply_stimulus(0, 1, 16'h0070); step(1);
        load = 1'b0; step(1);
        enable = 1'b1; step(1); check_output("lz70_d0", 4'hF, 4'h0);
        step(8); check_output("lz70_d1", 4'hF, 4'h7);
`ifdef LEADING_ZERO_BLANK_EN
        step(8); check_output("lz70_d2", 4'hF, 4'hF);
        step(8); check_output("lz70_d3", 4'hF, 4'hF);
`else
        step(8); check_output("lz70_d2", 4'hF, 4'h0);
        step(8); check_output("lz70_d3", 4'hF, 4'h0);
`endif
        apply_stimulus(0, 1, 16'h0000); step(1);
        load = 1'b0; step(1);
        enable = 1'b1; step(1); check_output("lz00_d0", 4'hF, 4'h0);
`ifdef LEADING_ZERO_BLANK_EN
        step(8); check_output("lz00_d1", 4'hF, 4'hF);
`else
        step(8); check_output("lz00_d1", 4'hF, 4'h0);
`endif

        // Randomized phase with an asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 149) != 0);
            load      = ($urandom_range(0, 19) == 0);
            digits_in = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1 check_output("async_reset", 4'hF, 4'hF);
                check_fd("async_reset_fd", 1'b0);
                step(1);
                rst_n = 1'b1;
            end else begin
                step(1);
            end
        end

        load = 1'b0;
        step(2);
        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
